// File: rtl/irq_encoder_8_3.sv
// 8-to-3 priority request encoder: captures request lines into a pending register
// and presents the highest-priority enabled source over a valid/ack handshake.
module irq_encoder_8_3 #(
  parameter bit EDGE_MODE = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] req,
  input  logic [7:0] mask,
  input  logic       ack,
  output logic       valid,
  output logic [2:0] code,
  output logic [7:0] pending,
  output logic       dbg_state
);

  // Handshake: code is offered while valid=1 and held frozen until the cycle
  // in which ack=1 is sampled; ack while valid=0 has no effect.
  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  state_t     state;
  logic [7:0] req_d;
  logic [7:0] set;
  logic [7:0] clr;
  logic [7:0] eligible;
  logic [2:0] enc;
  logic       any_eligible;

  assign dbg_state = state;

  // req_d resets low, so a line already high at reset release counts as an edge.
  always_comb begin
    set = req;
    if (EDGE_MODE) set = req & ~req_d;
  end

  always_comb begin
    clr = 8'h00;
    if (state == PRESENT && ack) clr = 8'h01 << code;
  end

  assign eligible     = pending & mask;
  assign any_eligible = |eligible;

  always_comb begin
    enc = 3'b000;
    for (int i = 0; i < 8; i++) begin
      if (eligible[i]) enc = 3'(i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      valid   <= 1'b0;
      code    <= 3'b000;
      pending <= 8'h00;
      req_d   <= 8'h00;
    end else begin
      req_d   <= req;
      pending <= (pending & ~clr) | set;
      case (state)
        IDLE: begin
          if (en && any_eligible) begin
            code  <= enc;
            valid <= 1'b1;
            state <= PRESENT;
          end
        end
        PRESENT: begin
          if (ack) begin
            valid <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          valid <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_irq_encoder_8_3.sv
// Bench for irq_encoder_8_3: an edge-mode and a level-mode instance driven side
// by side and compared each cycle against a behavioural model of the encoder.
module tb_irq_encoder_8_3;

  logic       clk;
  logic       rst;
  logic [7:0] req_v  [2];
  logic [7:0] mask_v [2];
  logic       en_v   [2];
  logic       ack_v  [2];
  logic       valid_o [2];
  logic [2:0] code_o  [2];
  logic [7:0] pend_o  [2];
  logic       dbg_o   [2];

  int checks;
  int errors;

  // model state, one slot per instance (0: edge mode, 1: level mode)
  logic [7:0] m_pend  [2];
  logic [7:0] m_req_d [2];
  logic       m_valid [2];
  logic [2:0] m_code  [2];

  irq_encoder_8_3 #(.EDGE_MODE(1'b1)) dut_edge (
    .clk(clk), .rst(rst), .en(en_v[0]), .req(req_v[0]), .mask(mask_v[0]),
    .ack(ack_v[0]), .valid(valid_o[0]), .code(code_o[0]), .pending(pend_o[0]),
    .dbg_state(dbg_o[0])
  );

  irq_encoder_8_3 #(.EDGE_MODE(1'b0)) dut_level (
    .clk(clk), .rst(rst), .en(en_v[1]), .req(req_v[1]), .mask(mask_v[1]),
    .ack(ack_v[1]), .valid(valid_o[1]), .code(code_o[1]), .pending(pend_o[1]),
    .dbg_state(dbg_o[1])
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_pend[k]  = 8'h00;
      m_req_d[k] = 8'h00;
      m_valid[k] = 1'b0;
      m_code[k]  = 3'b000;
    end
  endtask

  // One clock of the encoder's rules, using the inputs present at the edge.
  task automatic model_step(input int k);
    logic [7:0] np;
    int hi;
    np = m_pend[k];
    if (m_valid[k] && ack_v[k]) np[m_code[k]] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (k == 0) begin
        if (req_v[k][i] && !m_req_d[k][i]) np[i] = 1'b1;
      end else begin
        if (req_v[k][i]) np[i] = 1'b1;
      end
    end
    hi = -1;
    for (int i = 0; i < 8; i++) begin
      if (m_pend[k][i] && mask_v[k][i]) hi = i;
    end
    if (m_valid[k]) begin
      if (ack_v[k]) m_valid[k] = 1'b0;
    end else if (en_v[k] && hi >= 0) begin
      m_valid[k] = 1'b1;
      m_code[k]  = 3'(hi);
    end
    m_pend[k]  = np;
    m_req_d[k] = req_v[k];
  endtask

  task automatic compare_all();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("valid%0d", k), {7'b0, valid_o[k]}, {7'b0, m_valid[k]});
      check($sformatf("code%0d", k), {5'b0, code_o[k]}, {5'b0, m_code[k]});
      check($sformatf("pending%0d", k), pend_o[k], m_pend[k]);
      check($sformatf("state%0d", k), {7'b0, dbg_o[k]}, {7'b0, m_valid[k]});
    end
  endtask

  // driver: advance one clock and compare just after the edge
  task automatic tick();
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  // asynchronous reset asserted between edges, checked before the next edge
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drive(input int k, input logic [7:0] r, input logic [7:0] m,
                       input logic e, input logic a);
    req_v[k]  = r;
    mask_v[k] = m;
    en_v[k]   = e;
    ack_v[k]  = a;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    model_reset();
    rst = 1'b1;
    drive(0, 8'hFF, 8'hFF, 1'b1, 1'b0);
    drive(1, 8'h00, 8'hFF, 1'b1, 1'b0);
    #2;
    compare_all();
    check("reset_valid", {7'b0, valid_o[0]}, 8'h00);
    check("reset_pending", pend_o[0], 8'h00);
    @(negedge clk);
    drive(0, 8'h00, 8'hFF, 1'b1, 1'b0);
    rst = 1'b0;
    tick();
    tick();

    // single source pulse on req[5]
    drive(0, 8'h20, 8'hFF, 1'b1, 1'b0); tick();
    check("single_pend", pend_o[0], 8'h20);
    drive(0, 8'h00, 8'hFF, 1'b1, 1'b0); tick();
    check("single_code", {5'b0, code_o[0]}, 8'h05);
    check("single_valid", {7'b0, valid_o[0]}, 8'h01);
    drive(0, 8'h00, 8'hFF, 1'b1, 1'b1); tick();
    check("single_acked", pend_o[0], 8'h00);
    drive(0, 8'h00, 8'hFF, 1'b1, 1'b0); tick();

    // two sources rising together: 4 before 1
    drive(0, 8'h12, 8'hFF, 1'b1, 1'b0); tick();
    drive(0, 8'h12, 8'hFF, 1'b1, 1'b0); tick();
    check("prio_first", {5'b0, code_o[0]}, 8'h04);
    drive(0, 8'h12, 8'hFF, 1'b1, 1'b1); tick();
    drive(0, 8'h12, 8'hFF, 1'b1, 1'b0); tick();
    check("prio_second", {5'b0, code_o[0]}, 8'h01);
    drive(0, 8'h00, 8'hFF, 1'b1, 1'b1); tick();
    drive(0, 8'h00, 8'hFF, 1'b1, 1'b0); tick();

    // masked top source waits; mask change during presentation is ignored
    drive(0, 8'h84, 8'h7F, 1'b1, 1'b0); tick();
    drive(0, 8'h00, 8'h7F, 1'b1, 1'b0); tick();
    check("mask_code", {5'b0, code_o[0]}, 8'h02);
    drive(0, 8'h00, 8'hFF, 1'b0, 1'b0); tick();
    check("mask_frozen", {5'b0, code_o[0]}, 8'h02);
    drive(0, 8'h00, 8'hFF, 1'b1, 1'b1); tick();
    drive(0, 8'h00, 8'hFF, 1'b1, 1'b0); tick();
    check("mask_release", {5'b0, code_o[0]}, 8'h07);
    drive(0, 8'h00, 8'hFF, 1'b1, 1'b1); tick();

    // en low holds a pending source back
    drive(0, 8'h08, 8'hFF, 1'b0, 1'b0); tick();
    for (int i = 0; i < 3; i++) tick();
    check("en_hold", {7'b0, valid_o[0]}, 8'h00);
    drive(0, 8'h00, 8'hFF, 1'b1, 1'b0); tick();
    check("en_go", {5'b0, code_o[0]}, 8'h03);

    // new edge on req[3] in the ack cycle keeps the bit set
    drive(0, 8'h08, 8'hFF, 1'b1, 1'b1); tick();
    check("set_wins", pend_o[0], 8'h08);
    drive(0, 8'h00, 8'hFF, 1'b1, 1'b0); tick();
    check("represent", {5'b0, code_o[0]}, 8'h03);
    drive(0, 8'h00, 8'hFF, 1'b1, 1'b1); tick();
    drive(0, 8'h40, 8'h00, 1'b1, 1'b1); tick();
    drive(0, 8'h00, 8'h00, 1'b1, 1'b1); tick();
    check("ack_idle", pend_o[0], 8'h40);

    // reset in the middle of a presentation
    drive(0, 8'h00, 8'hFF, 1'b1, 1'b0); tick();
    do_reset();
    check("rst_mid", pend_o[0], 8'h00);
    tick();

    // level mode: held req[0] is re-presented after every ack
    drive(1, 8'h01, 8'hFF, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      ack_v[1] = valid_o[1];
      tick();
    end
    drive(1, 8'h00, 8'hFF, 1'b1, 1'b0);

    // randomized traffic on both instances
    for (int n = 0; n < 600; n++) begin
      for (int k = 0; k < 2; k++) begin
        if ($urandom_range(0, 3) == 0) req_v[k] = 8'($urandom_range(0, 255));
        mask_v[k] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'hFF;
        en_v[k]   = ($urandom_range(0, 4) != 0);
        ack_v[k]  = ($urandom_range(0, 1) == 1);
      end
      if ($urandom_range(0, 99) == 0) do_reset();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
